// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared encodings for the multicycle 8-bit MIPS controller. The state codes
// are fixed because the control-signal decoder maps each code directly to its
// datapath enables, so both blocks import this package.
package mips_ctrl_pkg;

  localparam int STATE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    FETCH1  = 6'd0,
    FETCH2  = 6'd1,
    FETCH3  = 6'd2,
    FETCH4  = 6'd3,
    DECODE  = 6'd4,
    MEMADR  = 6'd5,
    LBRD    = 6'd6,
    LBWR    = 6'd7,
    SBWR    = 6'd8,
    RTYPEEX = 6'd9,
    RTYPEWR = 6'd10,
    BEQEX   = 6'd11,
    JEX     = 6'd12
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/ctrl_nextstate.sv
// ctrl_nextstate
// Purely combinational next-state logic for the controller FSM.
// Ports:
//   state        current state code (may hold an unused encoding)
//   op           opcode field IR[31:26]
//   next_state   state code to load on the next clock edge
//   done_ev      current state is the final state of an instruction
//   illegal_ev   DECODE with an unsupported opcode
//   state_err_ev unused encoding, or op no longer a memory op in MEMADR
module ctrl_nextstate
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         op,
  output logic [STATE_W-1:0] next_state,
  output logic               done_ev,
  output logic               illegal_ev,
  output logic               state_err_ev
);

  // Next-state and event decode; every unlisted path falls back to FETCH1.
  always_comb begin
    next_state   = FETCH1;
    done_ev      = 1'b0;
    illegal_ev   = 1'b0;
    state_err_ev = 1'b0;
    case (state)
      FETCH1:  next_state = FETCH2;
      FETCH2:  next_state = FETCH3;
      FETCH3:  next_state = FETCH4;
      FETCH4:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_J:         next_state = JEX;
          default:      illegal_ev = 1'b1;
        endcase
      end
      MEMADR: begin
        // op is re-examined here; a change since DECODE is a sequencing fault
        case (op)
          OP_LB:   next_state = LBRD;
          OP_SB:   next_state = SBWR;
          default: state_err_ev = 1'b1;
        endcase
      end
      LBRD:    next_state = LBWR;
      RTYPEEX: next_state = RTYPEWR;
      LBWR, SBWR, RTYPEWR, BEQEX, JEX: done_ev = 1'b1;
      default: state_err_ev = 1'b1;
    endcase
  end

endmodule

// File: rtl/controller_fsm.sv
// controller_fsm
// Sequencing half of the multicycle 8-bit MIPS controller: state register,
// retired-instruction counter and sticky debug error flags.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   op         opcode IR[31:26], valid from DECODE onward
//   err_clr    synchronous clear of illegal_op, bad_op, state_err
//   state      current state code to the control-signal decoder
//   instr_done one-cycle pulse after an instruction's final state
//   retired    completed-instruction count, wraps silently
//   illegal_op sticky: DECODE saw an unsupported opcode
//   bad_op     first offending opcode since the last clear
//   state_err  sticky: unused encoding or op changed in MEMADR
module controller_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               err_clr,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired,
  output logic               illegal_op,
  output logic [5:0]         bad_op,
  output logic               state_err
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] next_state_s;
  logic               done_ev_s;
  logic               illegal_ev_s;
  logic               state_err_ev_s;
  logic               instr_done_r;
  logic [CNT_W-1:0]   retired_r;
  logic               illegal_op_r;
  logic [5:0]         bad_op_r;
  logic               state_err_r;

  ctrl_nextstate u_nextstate (
    .state        (state_r),
    .op           (op),
    .next_state   (next_state_s),
    .done_ev      (done_ev_s),
    .illegal_ev   (illegal_ev_s),
    .state_err_ev (state_err_ev_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH1;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Completion pulse and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_done_r <= 1'b0;
      retired_r    <= {CNT_W{1'b0}};
    end else begin
      instr_done_r <= done_ev_s;
      if (done_ev_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Sticky error flags; a new event on the clearing edge takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op_r <= 1'b0;
      bad_op_r     <= 6'd0;
      state_err_r  <= 1'b0;
    end else begin
      if (illegal_ev_s) begin
        illegal_op_r <= 1'b1;
      end else if (err_clr) begin
        illegal_op_r <= 1'b0;
      end else begin
        illegal_op_r <= illegal_op_r;
      end
      // err_clr discards the old capture, so the new opcode is taken even
      // when the flag was already set
      if (illegal_ev_s && (!illegal_op_r || err_clr)) begin
        bad_op_r <= op;
      end else if (err_clr) begin
        bad_op_r <= 6'd0;
      end else begin
        bad_op_r <= bad_op_r;
      end
      if (state_err_ev_s) begin
        state_err_r <= 1'b1;
      end else if (err_clr) begin
        state_err_r <= 1'b0;
      end else begin
        state_err_r <= state_err_r;
      end
    end
  end

  assign state      = state_r;
  assign instr_done = instr_done_r;
  assign retired    = retired_r;
  assign illegal_op = illegal_op_r;
  assign bad_op     = bad_op_r;
  assign state_err  = state_err_r;

endmodule

// File: doc/controller_fsm.md
Name: controller_fsm

Overview:
- Sequencing half of the multicycle 8-bit MIPS controller: state register plus next-state logic.
- Drives the 6-bit state code consumed by the control-signal decoder, which turns each state into memread/irwrite/pcwrite/alusrc/etc.
- Steps four byte-wide fetch cycles, decode, then the per-instruction execute path.
- Adds a sticky illegal-opcode/illegal-state flag and a retired-instruction counter for debug and bench visibility.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  opcode field IR[31:26]; valid from DECODE onward.
- err_clr  input  1  synchronous clear of the sticky error flags.
- state  output  6  current state code to the control-signal decoder.
- instr_done  output  1  registered one-cycle pulse after an instruction's final state.
- retired  output  CNT_W  count of completed instructions.
- illegal_op  output  1  sticky: DECODE saw an unsupported opcode.
- bad_op  output  6  opcode captured at the first illegal_op event.
- state_err  output  1  sticky: state register held an unused encoding.

Behaviour:
- State encoding is fixed because the decoder depends on it:
  - FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5
  - LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12
- Opcodes: LB=6'b100000, SB=6'b101000, RTYPE=6'b000000, BEQ=6'b000100, J=6'b000010.
- Transitions, one per clk:
  - FETCH1->FETCH2->FETCH3->FETCH4->DECODE.
  - DECODE: LB or SB -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; J -> JEX; any other opcode -> FETCH1.
  - MEMADR: LB -> LBRD; SB -> SBWR; any other opcode (op changed mid-instruction) -> FETCH1 and set state_err.
  - LBRD->LBWR; RTYPEEX->RTYPEWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX -> FETCH1.
  - Unused encodings 13..63 -> FETCH1 and set state_err.
- Instruction latency in cycles, FETCH1 to FETCH1: LB 8, SB 7, RTYPE 7, BEQ 6, J 6.
- Illegal opcode in DECODE: the next state is FETCH1. The instruction is not counted and no instr_done pulse is produced.
  - illegal_op sets on the same clock edge.
  - bad_op loads op only when illegal_op was previously 0; the first offending opcode is retained.
- Completion: the register update on the clock edge leaving LBWR, SBWR, RTYPEWR, BEQEX or JEX does the following.
  - Sets instr_done=1 for exactly the following cycle; otherwise instr_done=0.
  - Increments retired by 1, modulo 2^CNT_W; all-ones wraps to 0 with no flag.
- err_clr=1 clears illegal_op, state_err and bad_op at the next edge.
  - If a new error event occurs on the same edge, the set wins and bad_op captures the new op.
- Reset (asserted at any time, including mid-instruction) immediately forces:
  - state=FETCH1, instr_done=0, retired=0, illegal_op=0, bad_op=0, state_err=0.
  - After release, the first edge moves FETCH1->FETCH2.
- No combinational path from op to any output; all outputs come straight from flops.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the 13 state-code constants and the 6-bit state width;
  - the five opcode constants.
- The control-signal decoder also imports mips_ctrl_pkg so both blocks share one encoding.
- One natural sub-module: ctrl_nextstate, purely combinational, mapping (state, op) to next_state, plus done/illegal/state_err event strobes.
- The top level holds the state register, counter and sticky flags.

Test Plan:
- Reset, then 6 clocks with op=RTYPE: state sequence 0,1,2,3,4,9 and no instr_done. The next edge gives 10, then 0 with instr_done=1 and retired=1.
- op=LB across a full instruction:
  - state path is 0,1,2,3,4,5,6,7,0;
  - instr_done is seen one cycle after state 7;
  - retired increments by 1.
- op=SB then op=J then op=BEQ back-to-back: state paths 0-4,5,8 / 0-4,12 / 0-4,11 and retired=3. Per-instruction latencies are 7, 6, 6 cycles.
- op=6'b111111 at DECODE: next state 0, illegal_op=1, bad_op=63, retired unchanged. A second illegal op=6'b010101 leaves bad_op=63. Then err_clr=1 clears all three.
- Force state to 13, or switch op from LB to RTYPE while in MEMADR: next state 0, state_err=1, no count. Also assert err_clr together with an error event: the flag stays 1.
- CNT_W=4 with 16 RTYPE instructions: retired wraps 15->0. Then assert reset while in LBRD: state=0 and all flags/counter=0 immediately, with no clock edge needed.
